// File: rtl/instr_encoder_pkg.sv
// Shared encoder/decoder definitions: op selects, opcode/funct
// constants, instruction field positions and the buffered entry.
package instr_encoder_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_ORI  = 4'd3,
      OP_LW   = 4'd4,
      OP_SW   = 4'd5,
      OP_BEQ  = 4'd6,
      OP_LUI  = 4'd7,
      OP_ADDI = 4'd8,
      OP_J    = 4'd9,
      OP_JAL  = 4'd10,
      OP_SB   = 4'd11,
      OP_LB   = 4'd12,
      OP_JR   = 4'd13
   } op_e;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_LUI   = 6'b001111;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_JAL   = 6'b000011;
   localparam logic [5:0] OPC_SB    = 6'b101000;
   localparam logic [5:0] OPC_LB    = 6'b100000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int SH_LSB  = 6;
   localparam int FN_LSB  = 0;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] addr;
   } entry_t;

endpackage

// File: rtl/instr_encoder_fifo.sv
// Power-of-two FIFO holding encoded words with their addresses.
// Flush clears it synchronously and overrides any write or read.
module enc_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [W-1:0]               wr_data,
   input  logic                       rd_en,
   output logic [W-1:0]               rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   always_ff @(posedge clk) begin
      if (wr_en && !flush)
         mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en)
            wptr <= wptr + 1'b1;
         if (rd_en)
            rptr <= rptr + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rptr];
   assign empty   = (count == '0);

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: combinational encode, one register stage,
// then a FIFO of {word, address} entries toward the consumer.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int          DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_op,
   input  logic [4:0]             in_rs,
   input  logic [4:0]             in_rt,
   input  logic [4:0]             in_rd,
   input  logic [15:0]            in_imm,
   input  logic [25:0]            in_target,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_word,
   output logic [31:0]            out_addr,
   output logic                   err_illegal,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   enc_word;
   logic          legal;
   logic          accept;
   logic          push;
   logic          pop;
   logic          pipe_valid;
   entry_t        pipe;
   logic [31:0]   addr_q;
   logic          f_empty;
   logic          f_wr;
   logic          f_rd;
   entry_t        f_data;
   entry_t        head;
   logic [CW-1:0] f_count;

   always_comb begin
      enc_word = '0;
      legal    = 1'b1;
      unique case (in_op)
         OP_NOP:  enc_word = '0;
         OP_ADD:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
         OP_SUB:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
         OP_JR:   enc_word = {OPC_RTYPE, in_rs, 15'd0, FN_JR};
         OP_ORI:  enc_word = {OPC_ORI,  in_rs, in_rt, in_imm};
         OP_LW:   enc_word = {OPC_LW,   in_rs, in_rt, in_imm};
         OP_SW:   enc_word = {OPC_SW,   in_rs, in_rt, in_imm};
         OP_BEQ:  enc_word = {OPC_BEQ,  in_rs, in_rt, in_imm};
         OP_ADDI: enc_word = {OPC_ADDI, in_rs, in_rt, in_imm};
         OP_SB:   enc_word = {OPC_SB,   in_rs, in_rt, in_imm};
         OP_LB:   enc_word = {OPC_LB,   in_rs, in_rt, in_imm};
         OP_LUI:  enc_word = {OPC_LUI,  5'd0,  in_rt, in_imm};
         OP_J:    enc_word = {OPC_J,    in_target};
         OP_JAL:  enc_word = {OPC_JAL,  in_target};
         default: legal    = 1'b0;
      endcase
   end

   // Occupancy includes the staged entry so the bound is exact.
   assign count     = f_count + {{(CW-1){1'b0}}, pipe_valid};
   assign in_ready  = (count < FULL);
   assign accept    = in_valid & in_ready & ~flush;
   assign push      = accept & legal;
   assign out_valid = ~f_empty | pipe_valid;
   assign pop       = out_valid & out_ready;
   assign head      = f_empty ? pipe : f_data;
   assign out_word  = out_valid ? head.word : '0;
   assign out_addr  = out_valid ? head.addr : '0;

   // The staged entry always vacates: popped directly or moved on.
   assign f_rd = pop & ~f_empty & ~flush;
   assign f_wr = pipe_valid & ~(pop & f_empty) & ~flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_valid  <= 1'b0;
         pipe        <= '0;
         addr_q      <= BASE_ADDR;
         err_illegal <= 1'b0;
      end else if (flush) begin
         pipe_valid  <= 1'b0;
         pipe        <= '0;
         addr_q      <= BASE_ADDR;
         err_illegal <= 1'b0;
      end else begin
         pipe_valid  <= push;
         err_illegal <= accept & ~legal;
         if (push) begin
            pipe   <= '{word: enc_word, addr: addr_q};
            addr_q <= addr_q + 32'd4;
         end
      end
   end

   enc_fifo #(
      .DEPTH (DEPTH),
      .W     (64)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .wr_en   (f_wr),
      .wr_data (pipe),
      .rd_en   (f_rd),
      .rd_data (f_data),
      .empty   (f_empty),
      .count   (f_count)
   );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default instance plus one
// with a base address at the top of the address space.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [31:0] out_addr;
   logic        err_illegal;
   logic [2:0]  count;

   logic        b_valid;
   logic        b_in_ready;
   logic        b_out_valid;
   logic        b_ready;
   logic [31:0] b_word;
   logic [31:0] b_addr;
   logic        b_err;
   logic [2:0]  b_count;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .in_imm      (in_imm),
      .in_target   (in_target),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_word    (out_word),
      .out_addr    (out_addr),
      .err_illegal (err_illegal),
      .count       (count)
   );

   instr_encoder #(
      .BASE_ADDR (32'hFFFF_FFFC)
   ) dut_b (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (b_valid),
      .in_ready    (b_in_ready),
      .in_op       (in_op),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .in_imm      (in_imm),
      .in_target   (in_target),
      .out_valid   (b_out_valid),
      .out_ready   (b_ready),
      .out_word    (b_word),
      .out_addr    (b_addr),
      .err_illegal (b_err),
      .count       (b_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setf(input logic [3:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [25:0] tg);
      in_op     = op;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_imm    = imm;
      in_target = tg;
   endtask

   task automatic push(input bit sel_b, input logic [3:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tg);
      setf(op, rs, rt, rd, imm, tg);
      if (sel_b) b_valid = 1'b1;
      else       in_valid = 1'b1;
      tick();
      b_valid  = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      b_valid   = 1'b0;
      out_ready = 1'b0;
      b_ready   = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      setf(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
      do_reset();
      reset = 1'b0;
      tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_word", out_word, 32'd0);
      chk("rst_addr", out_addr, 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;

      // ori visible one cycle after accept
      push(0, 4'd3, 5'd0, 5'd8, 5'd0, 16'h1234, 26'd0);
      chk("ori_valid", 32'(out_valid), 32'd1);
      chk("ori_word", out_word, 32'h3408_1234);
      chk("ori_addr", out_addr, 32'h0000_3000);

      // add, lui, jal in order
      do_reset();
      push(0, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
      push(0, 4'd7, 5'd9, 5'd1, 5'd0, 16'hFFFF, 26'd0);
      push(0, 4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C03);
      chk("seq_count", 32'(count), 32'd3);
      chk("add_word", out_word, 32'h0022_1820);
      chk("add_addr", out_addr, 32'h0000_3000);
      out_ready = 1'b1;
      tick();
      chk("lui_word", out_word, 32'h3C01_FFFF);
      chk("lui_addr", out_addr, 32'h0000_3004);
      tick();
      chk("jal_word", out_word, 32'h0C00_0C03);
      chk("jal_addr", out_addr, 32'h0000_3008);
      tick();
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_word", out_word, 32'd0);
      chk("drain_count", 32'(count), 32'd0);
      out_ready = 1'b0;

      // fill to DEPTH, blocked push, pop-while-full, push+pop
      do_reset();
      for (int i = 0; i < 4; i++)
         push(0, 4'd3, 5'd0, 5'd0, 5'd0, 16'(i), 26'd0);
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd4);
      setf(4'd3, 5'd0, 5'd0, 5'd0, 16'h0055, 26'd0);
      in_valid = 1'b1;
      tick();
      chk("blk_count", 32'(count), 32'd4);
      chk("blk_word", out_word, 32'h3400_0000);
      chk("blk_addr", out_addr, 32'h0000_3000);
      out_ready = 1'b1;
      tick();
      chk("popfull_count", 32'(count), 32'd3);
      chk("popfull_word", out_word, 32'h3400_0001);
      chk("popfull_addr", out_addr, 32'h0000_3004);
      tick();
      chk("pushpop_count", 32'(count), 32'd3);
      chk("pushpop_word", out_word, 32'h3400_0002);
      in_valid = 1'b0;
      tick();
      tick();
      chk("tail_word", out_word, 32'h3400_0055);
      chk("tail_addr", out_addr, 32'h0000_3010);
      tick();
      chk("tail_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // illegal op then ori
      do_reset();
      push(0, 4'd15, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'd0);
      chk("ill_err", 32'(err_illegal), 32'd1);
      chk("ill_count", 32'(count), 32'd0);
      push(0, 4'd3, 5'd0, 5'd8, 5'd0, 16'h1234, 26'd0);
      chk("ill_err_clr", 32'(err_illegal), 32'd0);
      chk("ill_ori_word", out_word, 32'h3408_1234);
      chk("ill_ori_addr", out_addr, 32'h0000_3000);

      // flush with concurrent push and pop
      do_reset();
      for (int i = 0; i < 3; i++)
         push(0, 4'd8, 5'd1, 5'd2, 5'd0, 16'(i), 26'd0);
      chk("fl_pre_count", 32'(count), 32'd3);
      flush     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_valid", 32'(out_valid), 32'd0);
      push(0, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0);
      chk("fl_next_addr", out_addr, 32'h0000_3000);
      chk("fl_next_word", out_word, 32'h0022_1820);

      // asynchronous reset mid-stream
      do_reset();
      push(0, 4'd4, 5'd1, 5'd2, 5'd0, 16'h10, 26'd0);
      push(0, 4'd5, 5'd1, 5'd2, 5'd0, 16'h14, 26'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_addr", out_addr, 32'd0);
      tick();
      reset = 1'b1;
      push(0, 4'd13, 5'd31, 5'd7, 5'd7, 16'hFFFF, 26'd0);
      chk("ar_next_addr", out_addr, 32'h0000_3000);
      chk("jr_word", out_word, 32'h03E0_0008);

      // address wrap from the top of the space
      push(1, 4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C03);
      push(1, 4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C03);
      chk("wrap_addr0", b_addr, 32'hFFFF_FFFC);
      chk("wrap_word0", b_word, 32'h0C00_0C03);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      chk("wrap_addr1", b_addr, 32'h0000_0000);
      chk("wrap_word1", b_word, 32'h0800_0C03);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
